// File: rtl/cpu_exec_pkg.sv
// Shared opcodes, halt-cause codes and FSM encodings for the CPU execution controller.
package cpu_exec_pkg;

    localparam logic [2:0] CMD_RUN     = 3'd1;
    localparam logic [2:0] CMD_STEP    = 3'd2;
    localparam logic [2:0] CMD_STEP_N  = 3'd3;
    localparam logic [2:0] CMD_HALT    = 3'd4;
    localparam logic [2:0] CMD_CLR_CNT = 3'd5;

    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_HOST      = 3'd1;
    localparam logic [2:0] CAUSE_STEP_DONE = 3'd2;
    localparam logic [2:0] CAUSE_BP        = 3'd3;
    localparam logic [2:0] CAUSE_EBREAK    = 3'd4;

    typedef enum logic [1:0] {
        StHalted = 2'd0,
        StRun    = 2'd1,
        StStep   = 2'd2
    } state_e;

    // Index width that stays at least one bit even for a single slot.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_match_unit.sv
// Programmable PC breakpoint slots with equality comparators and a lowest-index priority encoder.
module bp_match_unit
    import cpu_exec_pkg::*;
#(
    parameter int unsigned NB_PC  = 32,
    parameter int unsigned N_BP   = 4,
    parameter int unsigned NB_IDX = clog2_min1(N_BP)
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_bp_wen,
    input  logic [NB_IDX-1:0] i_bp_idx,
    input  logic [NB_PC-1:0]  i_bp_addr,
    input  logic              i_bp_en,
    input  logic [NB_PC-1:0]  i_pc,
    output logic              o_match,
    output logic [NB_IDX-1:0] o_idx
);

    logic [NB_PC-1:0] r_bp_addr [N_BP];
    logic [N_BP-1:0]  r_bp_en;
    logic [N_BP-1:0]  w_hit;
    logic             w_idx_ok;

    // Only a non-power-of-two slot count can address a slot that does not exist.
    if (N_BP == (1 << NB_IDX)) begin : g_idx_full
        assign w_idx_ok = 1'b1;
    end else begin : g_idx_partial
        assign w_idx_ok = (i_bp_idx < NB_IDX'(N_BP));
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_BP; k++) begin
                r_bp_addr[k] <= '0;
            end
            r_bp_en <= '0;
        end else if (i_bp_wen && w_idx_ok) begin
            r_bp_addr[i_bp_idx] <= i_bp_addr;
            r_bp_en[i_bp_idx]   <= i_bp_en;
        end
    end

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < N_BP; k++) begin
            w_hit[k] = r_bp_en[k] && (r_bp_addr[k] == i_pc);
        end
    end

    assign o_match = |w_hit;

    always_comb begin
        o_idx = '0;
        for (int k = N_BP - 1; k >= 0; k--) begin
            if (w_hit[k]) o_idx = NB_IDX'(k);
        end
    end

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Execution controller: run / step / N-step / halt sequencing of the core advance-enable,
// with breakpoint and ebreak stops, halt-cause reporting and a saturating enabled-cycle counter.
module cpu_exec_ctrl
    import cpu_exec_pkg::*;
#(
    parameter int unsigned NB_PC   = 32,
    parameter int unsigned N_BP    = 4,
    parameter int unsigned NB_STEP = 16,
    parameter int unsigned NB_CNT  = 32
) (
    input  logic                         clk,
    input  logic                         i_rst_n,
    input  logic                         i_cmd_valid,
    input  logic [2:0]                   i_cmd,
    input  logic [NB_STEP-1:0]           i_step_count,
    input  logic                         i_bp_wen,
    input  logic [clog2_min1(N_BP)-1:0]  i_bp_idx,
    input  logic [NB_PC-1:0]             i_bp_addr,
    input  logic                         i_bp_en,
    input  logic [NB_PC-1:0]             i_pc,
    input  logic                         i_ebreak,
    output logic                         o_cpu_en,
    output logic                         o_halted,
    output logic                         o_done,
    output logic [2:0]                   o_halt_cause,
    output logic [clog2_min1(N_BP)-1:0]  o_bp_hit_idx,
    output logic                         o_cmd_err,
    output logic [NB_CNT-1:0]            o_cnt
);

    localparam int unsigned NB_IDX = clog2_min1(N_BP);

    state_e              r_state, w_state_nx;
    logic [NB_STEP-1:0]  r_remaining, w_remaining_nx;
    logic                r_skip, w_skip_nx;
    logic [2:0]          r_cause, w_cause_nx;
    logic [NB_IDX-1:0]   r_bp_hit_idx, w_bp_hit_idx_nx;
    logic                r_done, r_cmd_err, w_cmd_err_nx;
    logic [NB_CNT-1:0]   r_cnt, w_cnt_nx;

    logic                w_bp_match;
    logic [NB_IDX-1:0]   w_bp_idx;
    logic                w_halt_cmd, w_go_cmd, w_clr_cmd, w_stop, w_cpu_en;

    bp_match_unit #(
        .NB_PC  (NB_PC),
        .N_BP   (N_BP),
        .NB_IDX (NB_IDX)
    ) u_bp_match (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_bp_wen  (i_bp_wen),
        .i_bp_idx  (i_bp_idx),
        .i_bp_addr (i_bp_addr),
        .i_bp_en   (i_bp_en),
        .i_pc      (i_pc),
        .o_match   (w_bp_match),
        .o_idx     (w_bp_idx)
    );

    assign w_halt_cmd = i_cmd_valid && (i_cmd == CMD_HALT);
    assign w_clr_cmd  = i_cmd_valid && (i_cmd == CMD_CLR_CNT);
    assign w_go_cmd   = i_cmd_valid &&
                        ((i_cmd == CMD_RUN) || (i_cmd == CMD_STEP) || (i_cmd == CMD_STEP_N));
    // The skip cycle lets a resume execute the instruction it stopped on exactly once.
    assign w_stop     = !r_skip && (w_bp_match || i_ebreak);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StHalted;
            r_remaining  <= '0;
            r_skip       <= 1'b0;
            r_cause      <= CAUSE_NONE;
            r_bp_hit_idx <= '0;
            r_done       <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_remaining  <= w_remaining_nx;
            r_skip       <= w_skip_nx;
            r_cause      <= w_cause_nx;
            r_bp_hit_idx <= w_bp_hit_idx_nx;
            r_done       <= (r_state != StHalted) && (w_state_nx == StHalted);
            r_cmd_err    <= w_cmd_err_nx;
            r_cnt        <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_remaining_nx  = r_remaining;
        w_skip_nx       = r_skip;
        w_cause_nx      = r_cause;
        w_bp_hit_idx_nx = r_bp_hit_idx;
        w_cmd_err_nx    = 1'b0;
        w_cnt_nx        = r_cnt;

        if (i_cmd_valid) begin
            case (i_cmd)
                CMD_RUN, CMD_STEP, CMD_STEP_N: w_cmd_err_nx = (r_state != StHalted);
                CMD_HALT, CMD_CLR_CNT:         w_cmd_err_nx = 1'b0;
                default:                       w_cmd_err_nx = 1'b1;
            endcase
        end

        if (w_clr_cmd) begin
            w_cnt_nx = '0;
        end else if (w_cpu_en && (r_cnt != '1)) begin
            w_cnt_nx = r_cnt + NB_CNT'(1);
        end

        if (w_cpu_en) begin
            w_skip_nx = 1'b0;
            if (r_state == StStep) w_remaining_nx = r_remaining - NB_STEP'(1);
        end

        unique case (r_state)
            StHalted: begin
                if (w_go_cmd) begin
                    w_state_nx     = (i_cmd == CMD_RUN) ? StRun : StStep;
                    w_remaining_nx = ((i_cmd == CMD_STEP_N) && (i_step_count != '0)) ?
                                     i_step_count : NB_STEP'(1);
                    w_skip_nx      = 1'b1;
                    w_cause_nx     = CAUSE_NONE;
                end
            end
            StRun, StStep: begin
                if (w_stop) begin
                    w_state_nx = StHalted;
                    if (w_bp_match) begin
                        w_cause_nx      = CAUSE_BP;
                        w_bp_hit_idx_nx = w_bp_idx;
                    end else begin
                        w_cause_nx = CAUSE_EBREAK;
                    end
                end else if (w_halt_cmd) begin
                    w_state_nx = StHalted;
                    w_cause_nx = CAUSE_HOST;
                end else if ((r_state == StStep) && w_cpu_en &&
                             (r_remaining == NB_STEP'(1))) begin
                    w_state_nx = StHalted;
                    w_cause_nx = CAUSE_STEP_DONE;
                end
            end
            default: w_state_nx = StHalted;
        endcase
    end

    always_comb begin
        w_cpu_en = i_rst_n && (r_state != StHalted) && !w_stop && !w_halt_cmd;
    end

    assign o_cpu_en     = w_cpu_en;
    assign o_halted     = (r_state == StHalted);
    assign o_done       = r_done;
    assign o_halt_cause = r_cause;
    assign o_bp_hit_idx = r_bp_hit_idx;
    assign o_cmd_err    = r_cmd_err;
    assign o_cnt        = r_cnt;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed self-checking bench for cpu_exec_ctrl; counter narrowed to 8 bits to reach saturation.
module tb_cpu_exec_ctrl;
    import cpu_exec_pkg::*;

    localparam int unsigned NB_PC   = 32;
    localparam int unsigned N_BP    = 4;
    localparam int unsigned NB_STEP = 16;
    localparam int unsigned NB_CNT  = 8;

    logic               clk = 1'b0;
    logic               i_rst_n;
    logic               i_cmd_valid;
    logic [2:0]         i_cmd;
    logic [NB_STEP-1:0] i_step_count;
    logic               i_bp_wen;
    logic [1:0]         i_bp_idx;
    logic [NB_PC-1:0]   i_bp_addr;
    logic               i_bp_en;
    logic [NB_PC-1:0]   i_pc;
    logic               i_ebreak;
    logic               o_cpu_en;
    logic               o_halted;
    logic               o_done;
    logic [2:0]         o_halt_cause;
    logic [1:0]         o_bp_hit_idx;
    logic               o_cmd_err;
    logic [NB_CNT-1:0]  o_cnt;

    int n_cmp = 0;
    int n_mis = 0;
    int en_cnt, done_cnt, waited;
    logic prev_en;

    cpu_exec_ctrl #(
        .NB_PC   (NB_PC),
        .N_BP    (N_BP),
        .NB_STEP (NB_STEP),
        .NB_CNT  (NB_CNT)
    ) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_cmd_valid  (i_cmd_valid),
        .i_cmd        (i_cmd),
        .i_step_count (i_step_count),
        .i_bp_wen     (i_bp_wen),
        .i_bp_idx     (i_bp_idx),
        .i_bp_addr    (i_bp_addr),
        .i_bp_en      (i_bp_en),
        .i_pc         (i_pc),
        .i_ebreak     (i_ebreak),
        .o_cpu_en     (o_cpu_en),
        .o_halted     (o_halted),
        .o_done       (o_done),
        .o_halt_cause (o_halt_cause),
        .o_bp_hit_idx (o_bp_hit_idx),
        .o_cmd_err    (o_cmd_err),
        .o_cnt        (o_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] c);
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        i_cmd_valid = 1'b0;
        #1;
    endtask

    task automatic run_count(input int cycles, output int en_n, output int done_n);
        en_n   = 0;
        done_n = 0;
        for (int i = 0; i < cycles; i++) begin
            idle();
            if (o_cpu_en) en_n++;
            if (o_done) done_n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd = '0; i_step_count = '0;
        i_bp_wen = 1'b0; i_bp_idx = '0; i_bp_addr = '0; i_bp_en = 1'b0;
        i_pc = '0; i_ebreak = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cpu_en", o_cpu_en, 0);
        chk("rst_halted", o_halted, 1);
        chk("rst_done", o_done, 0);
        chk("rst_cause", o_halt_cause, 0);
        chk("rst_hit_idx", o_bp_hit_idx, 0);
        chk("rst_cmd_err", o_cmd_err, 0);
        chk("rst_cnt", o_cnt, 0);
        @(negedge clk);
        i_rst_n = 1'b1;

        // RUN for 10 enabled cycles; a redundant RUN mid-way must only flag an error
        issue(CMD_RUN);
        chk("run_cmd_cycle_en", o_cpu_en, 0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            i_cmd_valid = (i == 5);
            i_cmd       = CMD_RUN;
            #1;
            chk("run_en", o_cpu_en, 1);
            if (i == 1) chk("run_not_halted", o_halted, 0);
            if (i == 6) chk("run_in_run_err", o_cmd_err, 1);
            if (i == 7) chk("run_in_run_err_pulse", o_cmd_err, 0);
        end
        issue(CMD_HALT);
        chk("halt_forces_en_low", o_cpu_en, 0);
        chk("cnt_after_run10", o_cnt, 10);
        idle();
        chk("host_halted", o_halted, 1);
        chk("host_done", o_done, 1);
        chk("host_cause", o_halt_cause, CAUSE_HOST);
        issue(CMD_HALT);
        chk("host_done_pulse", o_done, 0);
        idle();
        chk("halt_in_halted_done", o_done, 0);
        chk("halt_in_halted_err", o_cmd_err, 0);
        chk("halt_in_halted_cause", o_halt_cause, CAUSE_HOST);

        issue(3'd7);
        idle();
        chk("reserved_err", o_cmd_err, 1);
        chk("reserved_halted", o_halted, 1);

        // STEP_N 3 then STEP_N 0 (treated as 1)
        i_step_count = 16'd3;
        issue(CMD_STEP_N);
        run_count(6, en_cnt, done_cnt);
        chk("stepn3_en_cycles", en_cnt, 3);
        chk("stepn3_done_pulses", done_cnt, 1);
        chk("stepn3_cause", o_halt_cause, CAUSE_STEP_DONE);
        chk("stepn3_halted", o_halted, 1);
        chk("stepn3_cnt", o_cnt, 13);
        i_step_count = 16'd0;
        issue(CMD_STEP_N);
        run_count(5, en_cnt, done_cnt);
        chk("stepn0_en_cycles", en_cnt, 1);
        chk("stepn0_done_pulses", done_cnt, 1);
        chk("stepn0_cnt", o_cnt, 14);

        // Breakpoints at 0x40 in slots 2 and 1; lowest slot reported
        @(negedge clk);
        i_bp_wen = 1'b1; i_bp_idx = 2'd2; i_bp_addr = 32'h40; i_bp_en = 1'b1;
        @(negedge clk);
        i_bp_idx = 2'd1;
        @(negedge clk);
        i_bp_wen = 1'b0;
        i_pc = 32'h38;
        i_cmd_valid = 1'b1;
        i_cmd = CMD_RUN;
        #1;
        prev_en = 1'b0;
        en_cnt  = 0;
        waited  = 0;
        do begin
            @(negedge clk);
            i_cmd_valid = 1'b0;
            if (prev_en) i_pc = i_pc + 32'd4;
            #1;
            prev_en = o_cpu_en;
            if (o_cpu_en) en_cnt++;
            waited++;
        end while (!o_halted && waited < 10);
        chk("bp_halted", o_halted, 1);
        chk("bp_en_cycles", en_cnt, 2);
        chk("bp_stop_pc", i_pc, 32'h40);
        chk("bp_done", o_done, 1);
        chk("bp_cause", o_halt_cause, CAUSE_BP);
        chk("bp_hit_idx", o_bp_hit_idx, 1);
        issue(CMD_RUN);
        idle();
        chk("bp_resume_en", o_cpu_en, 1);
        chk("bp_resume_cause", o_halt_cause, CAUSE_NONE);
        @(negedge clk);
        i_pc = 32'h44;
        #1;
        chk("bp_continue_en", o_cpu_en, 1);
        @(negedge clk);
        i_pc = 32'h48;
        i_cmd_valid = 1'b1;
        i_cmd = CMD_HALT;
        #1;
        idle();
        chk("bp_resume_cnt", o_cnt, 18);

        // ebreak together with HALT: ebreak wins
        @(negedge clk);
        i_pc = 32'h80;
        i_cmd_valid = 1'b1;
        i_cmd = CMD_RUN;
        #1;
        idle();
        chk("ebk_skip_en", o_cpu_en, 1);
        @(negedge clk);
        i_pc = 32'h84;
        i_ebreak = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd = CMD_HALT;
        #1;
        chk("ebk_stop_en", o_cpu_en, 0);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        i_ebreak = 1'b0;
        #1;
        chk("ebk_halted", o_halted, 1);
        chk("ebk_done", o_done, 1);
        chk("ebk_cause", o_halt_cause, CAUSE_EBREAK);
        idle();
        chk("ebk_done_pulse", o_done, 0);
        chk("ebk_cnt", o_cnt, 19);

        // Saturation and CLR_CNT priority over an increment
        issue(CMD_RUN);
        waited = 0;
        do begin
            idle();
            waited++;
        end while (o_cnt != 8'hFF && waited < 400);
        chk("sat_reached", o_cnt, 8'hFF);
        repeat (3) idle();
        chk("sat_hold", o_cnt, 8'hFF);
        chk("sat_running_en", o_cpu_en, 1);
        issue(CMD_CLR_CNT);
        chk("clr_cycle_en", o_cpu_en, 1);
        idle();
        chk("clr_cnt_zero", o_cnt, 0);
        chk("clr_no_err", o_cmd_err, 0);
        chk("clr_still_running", o_halted, 0);
        idle();
        chk("clr_then_count", o_cnt, 1);

        // Reset in the middle of STEP_N 5
        issue(CMD_HALT);
        idle();
        i_step_count = 16'd5;
        issue(CMD_STEP_N);
        idle();
        chk("stepn5_en", o_cpu_en, 1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_en", o_cpu_en, 0);
        chk("mid_rst_halted", o_halted, 1);
        @(negedge clk);
        i_rst_n = 1'b1;
        #1;
        chk("post_rst_cause", o_halt_cause, CAUSE_NONE);
        chk("post_rst_cnt", o_cnt, 0);
        chk("post_rst_halted", o_halted, 1);
        chk("post_rst_hit_idx", o_bp_hit_idx, 0);
        i_pc = 32'h40;
        issue(CMD_RUN);
        idle();
        chk("post_rst_skip_en", o_cpu_en, 1);
        idle();
        chk("post_rst_bp_cleared", o_cpu_en, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/cpu_exec_ctrl.md
Name: cpu_exec_ctrl

Overview:
- Parametrised execution controller that generates the CPU core's advance-enable.
- Successor to the single-bit run/stop enable produced inside the debug unit. Adds:
  - single-step and N-step modes
  - N_BP programmable PC breakpoints
  - ebreak halt
  - halt-cause reporting
  - an enabled-cycle counter
- Sits between the debug unit (command source) and the cpu core (o_cpu_en is ANDed with the subsystem enable).

Parameters:
- NB_PC, 32, width of program counter and breakpoint addresses
- N_BP, 4, number of breakpoint comparators (1..16)
- NB_STEP, 16, width of step-count operand
- NB_CNT, 32, width of enabled-cycle counter

Ports:
- clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command strobe, one cycle per command
- i_cmd  in  3  command: 1 RUN, 2 STEP, 3 STEP_N, 4 HALT, 5 CLR_CNT; others reserved
- i_step_count  in  NB_STEP  step count for STEP_N
- i_bp_wen  in  1  breakpoint register write strobe
- i_bp_idx  in  clog2(N_BP) (min 1)  breakpoint slot to write
- i_bp_addr  in  NB_PC  breakpoint PC value
- i_bp_en  in  1  breakpoint slot enable value
- i_pc  in  NB_PC  PC of instruction the core would execute when enabled
- i_ebreak  in  1  core decodes ebreak at i_pc
- o_cpu_en  out  1  core advance enable (combinational from registered state and inputs)
- o_halted  out  1  registered; 1 when in HALTED
- o_done  out  1  one-cycle pulse on entry to HALTED
- o_halt_cause  out  3  0 NONE, 1 HOST, 2 STEP_DONE, 3 BP, 4 EBREAK
- o_bp_hit_idx  out  clog2(N_BP)  lowest matching slot of last BP halt
- o_cmd_err  out  1  one-cycle pulse: reserved or rejected command
- o_cnt  out  NB_CNT  count of cycles with o_cpu_en=1, saturating

Behaviour:
- Reset values:
  - state HALTED, o_halted=1, o_done=0, o_halt_cause=0, o_bp_hit_idx=0, o_cmd_err=0, o_cnt=0.
  - All bp slots: enable=0, addr=0.
  - Step counter 0, skip flag 0.
- Reset mid-operation aborts immediately; o_cpu_en=0 while i_rst_n=0.
- States: HALTED, RUN, STEP.
- Commands in HALTED:
  - RUN: next state RUN.
  - STEP: next state STEP with remaining=1.
  - STEP_N: next state STEP with remaining=i_step_count; count 0 is treated as 1.
  - Entering RUN or STEP sets skip=1 and clears o_halt_cause to NONE.
- HALT:
  - Accepted in any state. In RUN or STEP: o_cpu_en forced 0 that cycle, next state HALTED, cause HOST.
  - In HALTED: no-op, no o_done, no o_cmd_err.
- CLR_CNT: accepted in any state; o_cnt=0 next cycle. Takes priority over an increment in the same cycle.
- RUN, STEP or STEP_N while not HALTED: ignored, o_cmd_err pulses. Reserved opcodes: o_cmd_err pulses.
- bp_match = OR over k of (bp_en[k] && bp_addr[k]==i_pc).
- stop = !skip && (bp_match || i_ebreak).
- o_cpu_en = (state != HALTED) && !stop && !(i_cmd_valid && i_cmd==HALT).
- skip clears after the first cycle with o_cpu_en=1. This lets a resume execute the instruction sitting on a breakpoint or ebreak exactly once.
- On stop, next state is HALTED with cause:
  - BP if bp_match; o_bp_hit_idx = lowest matching index.
  - Otherwise EBREAK.
  - The stopped instruction is not executed.
- Cause priority in the same cycle: BP > EBREAK > HOST.
- STEP state:
  - Each cycle with o_cpu_en=1 decrements remaining.
  - When remaining==1 and o_cpu_en=1, next state HALTED, cause STEP_DONE.
  - Breakpoints and ebreak are also checked in STEP (after the skip cycle).
- Latency:
  - Command to first o_cpu_en: 1 cycle.
  - Stop condition to o_halted=1 and o_done pulse: 1 cycle.
- Breakpoint writes: accepted in any state, visible to the comparator from the next cycle. An i_bp_idx >= N_BP is dropped.
- o_cnt increments on each cycle with o_cpu_en=1 and saturates at all-ones.

Decomposition:
- Package cpu_exec_pkg holds:
  - command opcodes (CMD_RUN..CMD_CLR_CNT)
  - halt-cause codes
  - state encodings
  - clog2 helper
- One natural sub-module: bp_match_unit. It holds the N_BP register array and comparators and outputs bp_match and the priority-encoded lowest index.

Test Plan:
- Reset, then RUN with no breakpoints or ebreak for 10 cycles -> o_cpu_en=1 from the cycle after the command; o_cnt=10; o_halted=0.
- STEP_N with i_step_count=3 -> exactly 3 o_cpu_en cycles, then o_halted=1, o_done pulse, cause=2. Repeat with count=0 -> exactly 1 cycle.
- bp slot 2 = 0x40 enabled, slot 1 = 0x40 enabled, RUN, i_pc reaches 0x40 -> o_cpu_en=0 that cycle, cause=3, o_bp_hit_idx=1. Then RUN again -> one o_cpu_en cycle at 0x40 and execution continues.
- RUN with i_ebreak=1 in the same cycle as a HALT command -> cause=4, single o_done pulse. Also check that RUN issued while in RUN pulses o_cmd_err and has no other effect.
- o_cnt at all-ones while running -> stays all-ones. CLR_CNT in the same cycle as an enabled cycle -> o_cnt=0.
- Assert i_rst_n=0 mid-STEP_N (remaining=5) -> o_cpu_en=0 immediately; after release: HALTED, cause 0, bp slots disabled.
